// File: rtl/pin_entry_if.sv
// Signal bundle between the card/keypad/Authenticator side and pin_entry_ctrl.
// The controller takes the slave view; whoever drives card, keypad and Authenticator takes master.
interface pin_entry_if;
    logic        card_in;
    logic [3:0]  acc_num_in;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        enter;
    logic        cancel;
    logic        acc_found_stat;
    logic        acc_auth_stat;
    logic [3:0]  acc_index_in;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic        auth_ok;
    logic [3:0]  acc_index;
    logic [1:0]  attempts_left;
    logic [1:0]  err_code;
    logic        eject;

    modport master (
        output card_in, acc_num_in, digit_valid, digit, enter, cancel,
               acc_found_stat, acc_auth_stat, acc_index_in,
        input  acc_num, pin, auth_ok, acc_index, attempts_left, err_code, eject
    );

    modport slave (
        input  card_in, acc_num_in, digit_valid, digit, enter, cancel,
               acc_found_stat, acc_auth_stat, acc_index_in,
        output acc_num, pin, auth_ok, acc_index, attempts_left, err_code, eject
    );
endinterface

// File: rtl/pin_entry_ctrl.sv
// ATM session front-end: latches the card account, builds a binary PIN from BCD keypad
// digits, checks it against the Authenticator, and handles retries, lockout, timeout, eject.
module pin_entry_ctrl #(
    parameter int MAX_ATTEMPTS = 3,
    parameter int TIMEOUT_CYC  = 1000,
    parameter int TMR_W        = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    pin_entry_if.slave     bus
);

    typedef enum logic [2:0] {IDLE, GET_PIN, CHECK, SESSION, EJECT} state_t;

    localparam logic [1:0]       ATT_INIT = 2'(MAX_ATTEMPTS);
    localparam logic [TMR_W-1:0] TMO      = TMR_W'(TIMEOUT_CYC);

    state_t           state, state_nxt;
    logic [2:0]       cnt;
    logic [TMR_W-1:0] tmr;
    logic [15:0]      lock;
    logic             timeout, full, dig_ok, last_try;
    logic [15:0]      pin_x10;

    assign timeout  = (tmr >= TMO);
    assign full     = (cnt == 3'd4);
    assign dig_ok   = bus.digit_valid && (bus.digit <= 4'd9) && !full;
    assign last_try = (bus.attempts_left == 2'd1);
    // pin*10 as shift-and-add; pin never exceeds 9999 so nothing is lost off the top
    assign pin_x10  = {bus.pin[12:0], 3'b000} + {bus.pin[14:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (bus.card_in) state_nxt = lock[bus.acc_num_in] ? EJECT : GET_PIN;
            GET_PIN:
                if (!bus.card_in)           state_nxt = IDLE;
                else if (bus.cancel)        state_nxt = EJECT;
                else if (timeout)           state_nxt = EJECT;
                else if (bus.enter && full) state_nxt = CHECK;
            CHECK:
                if (!bus.card_in)            state_nxt = IDLE;
                else if (!bus.acc_found_stat) state_nxt = EJECT;
                else if (bus.acc_auth_stat)  state_nxt = SESSION;
                else if (last_try)           state_nxt = EJECT;
                else                         state_nxt = GET_PIN;
            SESSION:
                if (!bus.card_in)     state_nxt = IDLE;
                else if (bus.cancel)  state_nxt = EJECT;
            EJECT:
                if (!bus.card_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.auth_ok = (state == SESSION);
        bus.eject   = (state == EJECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.acc_num       <= '0;
            bus.pin           <= '0;
            bus.acc_index     <= '0;
            bus.attempts_left <= ATT_INIT;
            bus.err_code      <= '0;
            cnt               <= '0;
            tmr               <= '0;
            lock              <= '0;
        end else begin
            bus.err_code <= 2'd0;
            case (state)
                IDLE: begin
                    if (bus.card_in) begin
                        bus.acc_num       <= bus.acc_num_in;
                        bus.pin           <= '0;
                        cnt               <= '0;
                        tmr               <= '0;
                        bus.attempts_left <= ATT_INIT;
                        if (lock[bus.acc_num_in]) bus.err_code <= 2'd3;
                    end
                end
                GET_PIN: begin
                    if (bus.card_in && !bus.cancel && !timeout) begin
                        if (bus.digit_valid || bus.enter) tmr <= '0;
                        else                              tmr <= tmr + 1'b1;
                        // enter wins over a same-cycle digit, which is dropped
                        if (!bus.enter && dig_ok) begin
                            bus.pin <= pin_x10 + {12'd0, bus.digit};
                            cnt     <= cnt + 3'd1;
                        end
                    end
                end
                CHECK: begin
                    if (bus.card_in) begin
                        if (!bus.acc_found_stat) begin
                            bus.err_code <= 2'd1;
                        end else if (bus.acc_auth_stat) begin
                            bus.acc_index <= bus.acc_index_in;
                        end else begin
                            bus.attempts_left <= bus.attempts_left - 2'd1;
                            if (last_try) begin
                                lock[bus.acc_num] <= 1'b1;
                                bus.err_code      <= 2'd3;
                            end else begin
                                bus.err_code <= 2'd2;
                                bus.pin      <= '0;
                                cnt          <= '0;
                                tmr          <= '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Directed bench for pin_entry_ctrl: a per-cycle vector table for the main flows plus
// hand-written sequences for lockout, cancel, card removal, timeout and async reset.
module tb_pin_entry_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pin_entry_if bus ();

    pin_entry_ctrl #(.MAX_ATTEMPTS(3), .TIMEOUT_CYC(1000), .TMR_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Authenticator stand-in: acc 1/2/3/8 exist with PINs 1234/2345/3456/9012
    always_comb begin
        bus.acc_found_stat = 1'b0;
        bus.acc_auth_stat  = 1'b0;
        bus.acc_index_in   = 4'd0;
        case (bus.acc_num)
            4'd1: begin bus.acc_found_stat = 1'b1; bus.acc_auth_stat = (bus.pin == 16'd1234); bus.acc_index_in = 4'd0; end
            4'd2: begin bus.acc_found_stat = 1'b1; bus.acc_auth_stat = (bus.pin == 16'd2345); bus.acc_index_in = 4'd1; end
            4'd3: begin bus.acc_found_stat = 1'b1; bus.acc_auth_stat = (bus.pin == 16'd3456); bus.acc_index_in = 4'd2; end
            4'd8: begin bus.acc_found_stat = 1'b1; bus.acc_auth_stat = (bus.pin == 16'd9012); bus.acc_index_in = 4'd3; end
            default: ;
        endcase
    end

    typedef struct {
        logic        card;
        logic [3:0]  acc;
        logic        dv;
        logic [3:0]  dig;
        logic        ent;
        logic        can;
        logic        ej;
        logic        au;
        logic [1:0]  err;
        logic [1:0]  att;
        logic [15:0] pin;
        logic [3:0]  idx;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(logic card, logic [3:0] acc, logic dv, logic [3:0] dig,
                               logic ent, logic can, logic ej, logic au, logic [1:0] err,
                               logic [1:0] att, logic [15:0] pin, logic [3:0] idx);
        vec_t r;
        r.card = card; r.acc = acc; r.dv = dv; r.dig = dig; r.ent = ent; r.can = can;
        r.ej = ej; r.au = au; r.err = err; r.att = att; r.pin = pin; r.idx = idx;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; outputs settle #1 after the rising edge.
    task automatic cyc(input logic card, input logic [3:0] acc, input logic dv,
                       input logic [3:0] dig, input logic ent, input logic can);
        @(negedge clk);
        bus.card_in = card; bus.acc_num_in = acc; bus.digit_valid = dv;
        bus.digit = dig; bus.enter = ent; bus.cancel = can;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.card_in = 0; bus.acc_num_in = 0; bus.digit_valid = 0;
        bus.digit = 0; bus.enter = 0; bus.cancel = 0;

        // acc 1, correct PIN first time, then cancel and pull the card
        vq.push_back(v(1,1,0,0,0,0, 0,0,0,3,0,0));
        vq.push_back(v(1,1,1,1,0,0, 0,0,0,3,1,0));
        vq.push_back(v(1,1,1,2,0,0, 0,0,0,3,12,0));
        vq.push_back(v(1,1,1,3,0,0, 0,0,0,3,123,0));
        vq.push_back(v(1,1,1,4,0,0, 0,0,0,3,1234,0));
        vq.push_back(v(1,1,0,0,1,0, 0,0,0,3,1234,0));
        vq.push_back(v(1,1,0,0,0,0, 0,1,0,3,1234,0));
        vq.push_back(v(1,1,0,0,0,0, 0,1,0,3,1234,0));
        vq.push_back(v(1,1,0,0,0,1, 1,0,0,3,1234,0));
        vq.push_back(v(0,0,0,0,0,0, 0,0,0,3,1234,0));
        // acc 2: two wrong tries, then correct; card pulled mid-session
        vq.push_back(v(1,2,0,0,0,0, 0,0,0,3,0,0));
        vq.push_back(v(1,2,1,1,0,0, 0,0,0,3,1,0));
        vq.push_back(v(1,2,1,1,0,0, 0,0,0,3,11,0));
        vq.push_back(v(1,2,1,1,0,0, 0,0,0,3,111,0));
        vq.push_back(v(1,2,1,1,0,0, 0,0,0,3,1111,0));
        vq.push_back(v(1,2,0,0,1,0, 0,0,0,3,1111,0));
        vq.push_back(v(1,2,0,0,0,0, 0,0,2,2,0,0));
        vq.push_back(v(1,2,1,1,0,0, 0,0,0,2,1,0));
        vq.push_back(v(1,2,1,1,0,0, 0,0,0,2,11,0));
        vq.push_back(v(1,2,1,1,0,0, 0,0,0,2,111,0));
        vq.push_back(v(1,2,1,1,0,0, 0,0,0,2,1111,0));
        vq.push_back(v(1,2,0,0,1,0, 0,0,0,2,1111,0));
        vq.push_back(v(1,2,0,0,0,0, 0,0,2,1,0,0));
        vq.push_back(v(1,2,1,2,0,0, 0,0,0,1,2,0));
        vq.push_back(v(1,2,1,3,0,0, 0,0,0,1,23,0));
        vq.push_back(v(1,2,1,4,0,0, 0,0,0,1,234,0));
        vq.push_back(v(1,2,1,5,0,0, 0,0,0,1,2345,0));
        vq.push_back(v(1,2,0,0,1,0, 0,0,0,1,2345,0));
        vq.push_back(v(1,2,0,0,0,0, 0,1,0,1,2345,1));
        vq.push_back(v(0,0,0,0,0,0, 0,0,0,1,2345,1));
        // acc 12 is unknown; a fifth digit is ignored
        vq.push_back(v(1,12,0,0,0,0, 0,0,0,3,0,1));
        vq.push_back(v(1,12,1,5,0,0, 0,0,0,3,5,1));
        vq.push_back(v(1,12,1,5,0,0, 0,0,0,3,55,1));
        vq.push_back(v(1,12,1,5,0,0, 0,0,0,3,555,1));
        vq.push_back(v(1,12,1,5,0,0, 0,0,0,3,5555,1));
        vq.push_back(v(1,12,1,9,0,0, 0,0,0,3,5555,1));
        vq.push_back(v(1,12,0,0,1,0, 0,0,0,3,5555,1));
        vq.push_back(v(1,12,0,0,0,0, 1,0,1,3,5555,1));
        vq.push_back(v(1,12,0,0,0,0, 1,0,0,3,5555,1));
        vq.push_back(v(0,0,0,0,0,0, 0,0,0,3,5555,1));
        // acc 8: non-BCD digit dropped, early enter ignored, digit+enter drops the digit
        vq.push_back(v(1,8,0,0,0,0, 0,0,0,3,0,1));
        vq.push_back(v(1,8,1,9,0,0, 0,0,0,3,9,1));
        vq.push_back(v(1,8,1,0,0,0, 0,0,0,3,90,1));
        vq.push_back(v(1,8,1,1,0,0, 0,0,0,3,901,1));
        vq.push_back(v(1,8,1,10,0,0, 0,0,0,3,901,1));
        vq.push_back(v(1,8,0,0,1,0, 0,0,0,3,901,1));
        vq.push_back(v(1,8,1,2,0,0, 0,0,0,3,9012,1));
        vq.push_back(v(1,8,1,7,1,0, 0,0,0,3,9012,1));
        vq.push_back(v(1,8,0,0,0,0, 0,1,0,3,9012,3));
        vq.push_back(v(1,8,0,0,0,1, 1,0,0,3,9012,3));
        vq.push_back(v(0,0,0,0,0,0, 0,0,0,3,9012,3));

        #12;
        chk("reset.eject", bus.eject, 0);
        chk("reset.att", bus.attempts_left, 3);
        chk("reset.pin", bus.pin, 0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            cyc(vq[i].card, vq[i].acc, vq[i].dv, vq[i].dig, vq[i].ent, vq[i].can);
            chk($sformatf("v%0d.eject", i), bus.eject, vq[i].ej);
            chk($sformatf("v%0d.auth_ok", i), bus.auth_ok, vq[i].au);
            chk($sformatf("v%0d.err", i), bus.err_code, vq[i].err);
            chk($sformatf("v%0d.att", i), bus.attempts_left, vq[i].att);
            chk($sformatf("v%0d.pin", i), bus.pin, vq[i].pin);
            chk($sformatf("v%0d.idx", i), bus.acc_index, vq[i].idx);
        end

        // acc 3: three wrong PINs lock it; reinsertion ejects straight away
        cyc(1,3,0,0,0,0);
        for (int k = 0; k < 3; k++) begin
            repeat (4) cyc(1,3,1,0,0,0);
            cyc(1,3,0,0,1,0);
            cyc(1,3,0,0,0,0);
            chk($sformatf("lock%0d.err", k), bus.err_code, (k < 2) ? 2 : 3);
            chk($sformatf("lock%0d.att", k), bus.attempts_left, 2 - k);
            chk($sformatf("lock%0d.eject", k), bus.eject, (k == 2) ? 1 : 0);
        end
        cyc(0,0,0,0,0,0);
        chk("lock.removed", bus.eject, 0);
        cyc(1,3,0,0,0,0);
        chk("relock.eject", bus.eject, 1);
        chk("relock.err", bus.err_code, 3);
        chk("relock.att", bus.attempts_left, 3);
        cyc(1,3,0,0,0,0);
        chk("relock.pulse", bus.err_code, 0);
        cyc(0,0,0,0,0,0);

        // cancel beats a same-cycle digit
        cyc(1,2,0,0,0,0);
        cyc(1,2,1,5,0,1);
        chk("cancel.eject", bus.eject, 1);
        chk("cancel.pin", bus.pin, 0);
        chk("cancel.err", bus.err_code, 0);
        cyc(0,0,0,0,0,0);

        // card pulled during PIN entry: back to IDLE silently, account not locked
        cyc(1,1,0,0,0,0);
        cyc(1,1,1,7,0,0);
        cyc(0,0,0,0,0,0);
        chk("pull.eject", bus.eject, 0);
        chk("pull.err", bus.err_code, 0);
        cyc(1,1,0,0,0,0);
        chk("pull.reinsert", bus.eject, 0);

        // inactivity timeout; a keypress part way restarts the count
        repeat (600) cyc(1,1,0,0,0,0);
        cyc(1,1,1,3,0,0);
        repeat (999) cyc(1,1,0,0,0,0);
        chk("tmo.early", bus.eject, 0);
        begin
            int n = 0;
            while (!bus.eject && n < 4) begin
                cyc(1,1,0,0,0,0);
                n++;
            end
            chk("tmo.eject", bus.eject, 1);
            chk("tmo.err", bus.err_code, 0);
        end
        cyc(0,0,0,0,0,0);

        // async reset in the middle of PIN entry
        cyc(1,8,0,0,0,0);
        cyc(1,8,1,4,0,0);
        cyc(1,8,1,2,0,0);
        chk("pre_rst.pin", bus.pin, 42);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst.pin", bus.pin, 0);
        chk("rst.acc_num", bus.acc_num, 0);
        chk("rst.idx", bus.acc_index, 0);
        chk("rst.att", bus.attempts_left, 3);
        chk("rst.auth", bus.auth_ok, 0);
        chk("rst.eject", bus.eject, 0);
        chk("rst.err", bus.err_code, 0);
        bus.card_in = 1'b0;
        #20;
        rst_n = 1'b1;
        // lock bitmap cleared by reset: acc 3 enters PIN entry again
        cyc(1,3,0,0,0,0);
        chk("rst.unlock", bus.eject, 0);
        chk("rst.unlock_err", bus.err_code, 0);
        cyc(0,0,0,0,0,0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
